// File: rtl/csr_mcnt.sv
// Machine-mode CSR file: trap/mret bookkeeping, WARL-masked control registers,
// 64-bit cycle/instret/HPM counters and a registered interrupt request.
module csr_mcnt #(
  parameter int unsigned NUM_HPM  = 2,
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter bit          VECTORED = 1'b1,
  localparam int unsigned HPM_W   = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic             ctrl_clk,
  input  logic             ctrl_reset,
  input  logic [11:0]      raddr,
  output logic [31:0]      rdata,
  output logic             ctrl_addr_valid,
  input  logic             wen,
  input  logic [11:0]      waddr,
  input  logic [31:0]      wdata,
  input  logic             ctrl_trap,
  input  logic             ctrl_mret,
  input  logic [31:0]      trap_pc,
  input  logic [4:0]       trap_info,
  input  logic [31:0]      trap_tval,
  input  logic             ctrl_retire,
  input  logic [HPM_W-1:0] hpm_event,
  input  logic [2:0]       ctrl_mxip,
  output logic             ctrl_irq_req,
  output logic [4:0]       ctrl_irq_cause,
  output logic [31:0]      trap_target,
  output logic [31:0]      mret_target
);

  localparam int unsigned NCNT        = 2 + NUM_HPM;
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK    = 32'hFFFF_0888;
  localparam logic [31:0] INH_MASK    = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
  localparam logic [6:0]  CNT_LO_PAGE = 7'h58;
  localparam logic [6:0]  CNT_HI_PAGE = 7'h5C;

  // Counter k lives at offset 0 (mcycle), 2 (minstret) or k+1 (mhpmcounter3..).
  function automatic logic [4:0] cnt_off(input int k);
    return (k == 0) ? 5'd0 : 5'(k + 1);
  endfunction

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] inhibit_q, inhibit_d;
  logic [63:0] cnt_q [NCNT];
  logic [63:0] cnt_d [NCNT];
  logic        irq_req_q, irq_req_d;
  logic [4:0]  irq_cause_q, irq_cause_d;

  logic [31:0]     mstatus_rd, mip_val, pending;
  logic [31:0]     rd_cur, wr_val;
  logic            rd_ok, wr_ok, wr_en;
  logic [NCNT-1:0] inc;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mip_val    = {20'b0, ctrl_mxip[0], 3'b0, ctrl_mxip[2], 3'b0, ctrl_mxip[1], 3'b0};
  assign pending    = mip_val & mie_q;
  assign wr_en      = wen && !ctrl_trap;

  // Current-state read mux.
  always_comb begin
    rd_cur = 32'h0;
    rd_ok  = 1'b1;
    case (raddr)
      12'h300: rd_cur = mstatus_rd;
      12'h301: rd_cur = MISA_VAL;
      12'h304: rd_cur = mie_q;
      12'h305: rd_cur = mtvec_q;
      12'h320: rd_cur = inhibit_q;
      12'h340: rd_cur = mscratch_q;
      12'h341: rd_cur = mepc_q;
      12'h342: rd_cur = mcause_q;
      12'h343: rd_cur = mtval_q;
      12'h344: rd_cur = mip_val;
      12'hF14: rd_cur = HART_ID;
      default: begin
        rd_ok = 1'b0;
        if (raddr[11:5] == CNT_LO_PAGE || raddr[11:5] == CNT_HI_PAGE) begin
          for (int k = 0; k < NCNT; k++) begin
            if (raddr[4:0] == cnt_off(k)) begin
              rd_ok  = 1'b1;
              rd_cur = raddr[7] ? cnt_q[k][63:32] : cnt_q[k][31:0];
            end
          end
        end
      end
    endcase
  end

  // Post-WARL write value and whether the write is accepted at all.
  always_comb begin
    wr_val = wdata;
    wr_ok  = 1'b1;
    case (waddr)
      12'h300: wr_val = {19'b0, 2'b11, 3'b0, wdata[7], 3'b0, wdata[3], 3'b0};
      12'h304: wr_val = wdata & MIE_MASK;
      12'h305: wr_ok  = (wdata[1:0] == 2'b00) || (wdata[1:0] == 2'b01 && VECTORED);
      12'h320: wr_val = wdata & INH_MASK;
      12'h340: wr_val = wdata;
      12'h341: wr_val = {wdata[31:2], 2'b00};
      12'h342: wr_val = {wdata[31], 27'b0, wdata[3:0]};
      12'h343: wr_val = wdata;
      default: begin
        wr_ok = 1'b0;
        if (waddr[11:5] == CNT_LO_PAGE || waddr[11:5] == CNT_HI_PAGE) begin
          for (int k = 0; k < NCNT; k++) begin
            if (waddr[4:0] == cnt_off(k)) wr_ok = 1'b1;
          end
        end
      end
    endcase
  end

  assign rdata           = (wr_en && wr_ok && (waddr == raddr)) ? wr_val : rd_cur;
  assign ctrl_addr_valid = rd_ok;

  always_comb begin
    inc    = '0;
    inc[0] = !inhibit_q[0];
    inc[1] = ctrl_retire && !inhibit_q[2];
    for (int i = 0; i < NUM_HPM; i++) inc[2+i] = hpm_event[i] && !inhibit_q[3+i];
  end

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    inhibit_d  = inhibit_q;
    if (ctrl_trap) begin
      if (ctrl_mret) begin
        st_mie_d  = st_mpie_q;
        st_mpie_d = 1'b1;
      end else begin
        st_mpie_d = st_mie_q;
        st_mie_d  = 1'b0;
        mepc_d    = {trap_pc[31:2], 2'b00};
        mcause_d  = {trap_info[4], 27'b0, trap_info[3:0]};
        mtval_d   = trap_tval;
      end
    end else if (wr_en && wr_ok) begin
      case (waddr)
        12'h300: begin
          st_mie_d  = wr_val[3];
          st_mpie_d = wr_val[7];
        end
        12'h304: mie_d      = wr_val;
        12'h305: mtvec_d    = wr_val;
        12'h320: inhibit_d  = wr_val;
        12'h340: mscratch_d = wr_val;
        12'h341: mepc_d     = wr_val;
        12'h342: mcause_d   = wr_val;
        12'h343: mtval_d    = wr_val;
        default: ;
      endcase
    end
    // A half-write replaces that half and cancels the counter's increment.
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k] + {63'b0, inc[k]};
      if (wr_en && waddr[4:0] == cnt_off(k)) begin
        if (waddr[11:5] == CNT_LO_PAGE) cnt_d[k] = {cnt_q[k][63:32], wdata};
        if (waddr[11:5] == CNT_HI_PAGE) cnt_d[k] = {wdata, cnt_q[k][31:0]};
      end
    end
  end

  always_comb begin
    irq_req_d   = st_mie_q && (|pending) && !ctrl_trap;
    irq_cause_d = 5'h0;
    if (irq_req_d) begin
      if (pending[11])     irq_cause_d = 5'h1B;
      else if (pending[3]) irq_cause_d = 5'h13;
      else                 irq_cause_d = 5'h17;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      st_mie_q    <= 1'b0;
      st_mpie_q   <= 1'b0;
      mie_q       <= 32'h0;
      mtvec_q     <= 32'h0;
      mscratch_q  <= 32'h0;
      mepc_q      <= 32'h0;
      mcause_q    <= 32'h0;
      mtval_q     <= 32'h0;
      inhibit_q   <= 32'h0;
      irq_req_q   <= 1'b0;
      irq_cause_q <= 5'h0;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= 64'h0;
    end else begin
      st_mie_q    <= st_mie_d;
      st_mpie_q   <= st_mpie_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      inhibit_q   <= inhibit_d;
      irq_req_q   <= irq_req_d;
      irq_cause_q <= irq_cause_d;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign ctrl_irq_req   = irq_req_q;
  assign ctrl_irq_cause = irq_cause_q;
  assign trap_target    = (mtvec_q[1:0] == 2'b01 && trap_info[4])
                        ? {mtvec_q[31:2], 2'b00} + {26'b0, trap_info[3:0], 2'b00}
                        : {mtvec_q[31:2], 2'b00};
  assign mret_target    = mepc_q;

endmodule

// File: tb/tb_csr_mcnt.sv
// Directed bench for csr_mcnt: counters, WARL masks, traps/mret and interrupt requests.
module tb_csr_mcnt;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic [11:0] raddr = '0;
  logic [31:0] rdata;
  logic        ctrl_addr_valid;
  logic        wen = 1'b0;
  logic [11:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        ctrl_trap = 1'b0;
  logic        ctrl_mret = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [4:0]  trap_info = '0;
  logic [31:0] trap_tval = '0;
  logic        ctrl_retire = 1'b0;
  logic [1:0]  hpm_event = '0;
  logic [2:0]  ctrl_mxip = '0;
  logic        ctrl_irq_req;
  logic [4:0]  ctrl_irq_cause;
  logic [31:0] trap_target;
  logic [31:0] mret_target;

  int n_checks = 0;
  int n_pass   = 0;

  csr_mcnt dut (
    .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset),
    .raddr(raddr), .rdata(rdata), .ctrl_addr_valid(ctrl_addr_valid),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .ctrl_trap(ctrl_trap), .ctrl_mret(ctrl_mret), .trap_pc(trap_pc),
    .trap_info(trap_info), .trap_tval(trap_tval),
    .ctrl_retire(ctrl_retire), .hpm_event(hpm_event), .ctrl_mxip(ctrl_mxip),
    .ctrl_irq_req(ctrl_irq_req), .ctrl_irq_cause(ctrl_irq_cause),
    .trap_target(trap_target), .mret_target(mret_target)
  );

  always #10 ctrl_clk = ~ctrl_clk;

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    raddr = a;
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    tick(); tick();
    ctrl_reset = 1'b0;
    repeat (10) tick();
    rd(12'hB00); n_checks++;
    if (rdata !== 32'd10) $display("FAIL reset_mcycle: got %h exp %h", rdata, 32'd10); else n_pass++;
    rd(12'hB02); n_checks++;
    if (rdata !== 32'd0) $display("FAIL reset_minstret: got %h exp 0", rdata); else n_pass++;
    rd(12'h300); n_checks++;
    if (rdata !== 32'h1800) $display("FAIL reset_mstatus: got %h exp 1800", rdata); else n_pass++;
    rd(12'h301); n_checks++;
    if (rdata !== 32'h40000100 || ctrl_addr_valid !== 1'b1)
      $display("FAIL reset_misa: got %h/%b exp 40000100/1", rdata, ctrl_addr_valid); else n_pass++;
    rd(12'hF14); n_checks++;
    if (rdata !== 32'h0) $display("FAIL reset_mhartid: got %h exp 0", rdata); else n_pass++;
    n_checks++;
    if (ctrl_irq_req !== 1'b0 || ctrl_irq_cause !== 5'h0)
      $display("FAIL reset_irq: got %b/%h exp 0/00", ctrl_irq_req, ctrl_irq_cause); else n_pass++;
  endtask

  task automatic test_wrap();
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0);
    tick();
    rd(12'hB00); n_checks++;
    if (rdata !== 32'h0) $display("FAIL carry_lo: got %h exp 0", rdata); else n_pass++;
    rd(12'hB80); n_checks++;
    if (rdata !== 32'h1) $display("FAIL carry_hi: got %h exp 1", rdata); else n_pass++;
    tick();
    rd(12'hB00); n_checks++;
    if (rdata !== 32'h1) $display("FAIL wrap_lo: got %h exp 1", rdata); else n_pass++;
    rd(12'hB80); n_checks++;
    if (rdata !== 32'h1) $display("FAIL wrap_hi: got %h exp 1", rdata); else n_pass++;
  endtask

  task automatic test_inhibit();
    wen = 1'b1; waddr = 12'h320; wdata = 32'hFFFF_FFFF;
    rd(12'h320); n_checks++;
    if (rdata !== 32'h1D) $display("FAIL bypass_inhibit: got %h exp 1d", rdata); else n_pass++;
    tick();
    wen = 1'b0;
    rd(12'h320); n_checks++;
    if (rdata !== 32'h1D) $display("FAIL inhibit_mask: got %h exp 1d", rdata); else n_pass++;
    csr_write(12'h320, 32'h1);
    repeat (5) tick();
    rd(12'hB00); n_checks++;
    if (rdata !== 32'h2) $display("FAIL inhibit_mcycle: got %h exp 2", rdata); else n_pass++;
    ctrl_retire = 1'b1;
    repeat (3) tick();
    ctrl_retire = 1'b0;
    rd(12'hB02); n_checks++;
    if (rdata !== 32'h3) $display("FAIL minstret_count: got %h exp 3", rdata); else n_pass++;
    ctrl_retire = 1'b1;
    csr_write(12'hB02, 32'h55);
    ctrl_retire = 1'b0;
    rd(12'hB02); n_checks++;
    if (rdata !== 32'h55) $display("FAIL minstret_write: got %h exp 55", rdata); else n_pass++;
    hpm_event = 2'b01;
    repeat (4) tick();
    hpm_event = 2'b00;
    rd(12'hB03); n_checks++;
    if (rdata !== 32'h4) $display("FAIL hpm3_count: got %h exp 4", rdata); else n_pass++;
    rd(12'hB04); n_checks++;
    if (rdata !== 32'h0) $display("FAIL hpm4_idle: got %h exp 0", rdata); else n_pass++;
    csr_write(12'hB83, 32'hA5);
    rd(12'hB83); n_checks++;
    if (rdata !== 32'hA5) $display("FAIL hpm3_hi_write: got %h exp a5", rdata); else n_pass++;
    rd(12'hB03); n_checks++;
    if (rdata !== 32'h4) $display("FAIL hpm3_lo_kept: got %h exp 4", rdata); else n_pass++;
  endtask

  task automatic test_irq();
    csr_write(12'h305, 32'h101);
    csr_write(12'h305, 32'h203);
    rd(12'h305); n_checks++;
    if (rdata !== 32'h101) $display("FAIL mtvec_reject: got %h exp 101", rdata); else n_pass++;
    csr_write(12'h304, 32'hFFFF_FFFF);
    rd(12'h304); n_checks++;
    if (rdata !== 32'hFFFF0888) $display("FAIL mie_mask: got %h exp ffff0888", rdata); else n_pass++;
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    ctrl_mxip = 3'b110;
    tick();
    n_checks++;
    if (ctrl_irq_req !== 1'b1 || ctrl_irq_cause !== 5'h13)
      $display("FAIL irq_msi: got %b/%h exp 1/13", ctrl_irq_req, ctrl_irq_cause); else n_pass++;
    rd(12'h344); n_checks++;
    if (rdata !== 32'h88) $display("FAIL mip_view: got %h exp 88", rdata); else n_pass++;
    ctrl_trap = 1'b1; trap_info = 5'h13; trap_pc = 32'h8000_1237; trap_tval = 32'hDEAD_BEEF;
    #1; n_checks++;
    if (trap_target !== 32'h10C) $display("FAIL trap_target_vec: got %h exp 10c", trap_target); else n_pass++;
    tick();
    ctrl_trap = 1'b0;
    n_checks++;
    if (ctrl_irq_req !== 1'b0) $display("FAIL irq_after_trap: got %b exp 0", ctrl_irq_req); else n_pass++;
    rd(12'h300); n_checks++;
    if (rdata !== 32'h1880) $display("FAIL trap_mstatus: got %h exp 1880", rdata); else n_pass++;
    rd(12'h341); n_checks++;
    if (rdata !== 32'h8000_1234) $display("FAIL trap_mepc: got %h exp 80001234", rdata); else n_pass++;
    rd(12'h342); n_checks++;
    if (rdata !== 32'h8000_0003) $display("FAIL trap_mcause: got %h exp 80000003", rdata); else n_pass++;
    rd(12'h343); n_checks++;
    if (rdata !== 32'hDEAD_BEEF) $display("FAIL trap_mtval: got %h exp deadbeef", rdata); else n_pass++;
    trap_info = 5'h03;
    #1; n_checks++;
    if (trap_target !== 32'h100) $display("FAIL trap_target_exc: got %h exp 100", trap_target); else n_pass++;
    rd(12'h7C0); n_checks++;
    if (rdata !== 32'h0 || ctrl_addr_valid !== 1'b0)
      $display("FAIL unimpl_read: got %h/%b exp 0/0", rdata, ctrl_addr_valid); else n_pass++;
    csr_write(12'h301, 32'h0);
    rd(12'h301); n_checks++;
    if (rdata !== 32'h40000100) $display("FAIL misa_readonly: got %h exp 40000100", rdata); else n_pass++;
  endtask

  task automatic test_trap_write();
    ctrl_mxip = 3'b000;
    csr_write(12'h300, 32'h8);
    csr_write(12'h340, 32'h11);
    ctrl_trap = 1'b1; trap_info = 5'h02; trap_pc = 32'h2003; ctrl_retire = 1'b1;
    wen = 1'b1; waddr = 12'h340; wdata = 32'h99;
    tick();
    ctrl_trap = 1'b0; wen = 1'b0; ctrl_retire = 1'b0;
    rd(12'h340); n_checks++;
    if (rdata !== 32'h11) $display("FAIL trap_drops_write: got %h exp 11", rdata); else n_pass++;
    rd(12'h341); n_checks++;
    if (rdata !== 32'h2000) $display("FAIL trap_mepc_align: got %h exp 2000", rdata); else n_pass++;
    rd(12'h300); n_checks++;
    if (rdata !== 32'h1880) $display("FAIL trap2_mstatus: got %h exp 1880", rdata); else n_pass++;
    rd(12'hB02); n_checks++;
    if (rdata !== 32'h56) $display("FAIL trap_counts: got %h exp 56", rdata); else n_pass++;
    ctrl_trap = 1'b1; ctrl_mret = 1'b1;
    tick();
    ctrl_trap = 1'b0; ctrl_mret = 1'b0;
    rd(12'h300); n_checks++;
    if (rdata !== 32'h1888) $display("FAIL mret_mstatus: got %h exp 1888", rdata); else n_pass++;
    n_checks++;
    if (mret_target !== 32'h2000) $display("FAIL mret_target: got %h exp 2000", mret_target); else n_pass++;
  endtask

  task automatic test_irq_priority();
    n_checks++;
    if (ctrl_irq_req !== 1'b0) $display("FAIL irq_after_mret: got %b exp 0", ctrl_irq_req); else n_pass++;
    ctrl_mxip = 3'b111;
    tick();
    n_checks++;
    if (ctrl_irq_req !== 1'b1 || ctrl_irq_cause !== 5'h1B)
      $display("FAIL irq_mei: got %b/%h exp 1/1b", ctrl_irq_req, ctrl_irq_cause); else n_pass++;
    ctrl_mxip = 3'b100;
    tick();
    n_checks++;
    if (ctrl_irq_req !== 1'b1 || ctrl_irq_cause !== 5'h17)
      $display("FAIL irq_mti: got %b/%h exp 1/17", ctrl_irq_req, ctrl_irq_cause); else n_pass++;
    ctrl_mxip = 3'b000;
    tick();
    n_checks++;
    if (ctrl_irq_req !== 1'b0) $display("FAIL irq_clear: got %b exp 0", ctrl_irq_req); else n_pass++;
  endtask

  task automatic test_reset_mid();
    csr_write(12'h320, 32'h0);
    repeat (3) tick();
    ctrl_reset = 1'b1; ctrl_trap = 1'b1; trap_pc = 32'h4444;
    wen = 1'b1; waddr = 12'h340; wdata = 32'h77;
    tick();
    ctrl_reset = 1'b0; ctrl_trap = 1'b0; wen = 1'b0;
    rd(12'hB00); n_checks++;
    if (rdata !== 32'h0) $display("FAIL midreset_mcycle: got %h exp 0", rdata); else n_pass++;
    rd(12'h340); n_checks++;
    if (rdata !== 32'h0) $display("FAIL midreset_mscratch: got %h exp 0", rdata); else n_pass++;
    rd(12'h341); n_checks++;
    if (rdata !== 32'h0) $display("FAIL midreset_mepc: got %h exp 0", rdata); else n_pass++;
    rd(12'h305); n_checks++;
    if (rdata !== 32'h0) $display("FAIL midreset_mtvec: got %h exp 0", rdata); else n_pass++;
    rd(12'h300); n_checks++;
    if (rdata !== 32'h1800) $display("FAIL midreset_mstatus: got %h exp 1800", rdata); else n_pass++;
    tick();
    rd(12'hB00); n_checks++;
    if (rdata !== 32'h1) $display("FAIL resume_mcycle: got %h exp 1", rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_inhibit();
    test_irq();
    test_trap_write();
    test_irq_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
